// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words and streams them to a stallable
// instruction-memory write port. Define IMM_CHECK_EN to reject immediates that overflow their field.
module instr_encoder #(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   output logic                  full,
   output logic                  err
);

   typedef enum logic [6:0] {
      OpLoad   = 7'h03,
      OpImm    = 7'h13,
      OpAuipc  = 7'h17,
      OpStore  = 7'h23,
      OpReg    = 7'h33,
      OpLui    = 7'h37,
      OpBranch = 7'h63,
      OpJalr   = 7'h67,
      OpJal    = 7'h6f
   } opcode_e;

   localparam logic [31:0]           NopWord  = 32'h0000_0013;
   localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  full_q, full_d;
   logic                  err_q, err_d;

   logic        accept;
   logic        handshake;
   logic        shift_op;
   logic        op_ok;
   logic        imm_ok;
   logic [31:0] enc_raw;
   logic [31:0] enc_word;
   logic        enc_err;

   assign in_ready  = !full_q && !flush && (!we_q || mem_ready);
   assign accept    = in_valid && in_ready;
   assign handshake = we_q && mem_ready;

   // slli/srli/srai carry funct7 in the upper immediate bits
   assign shift_op = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   // Field packing; op_ok drops for opcodes outside RV32I base.
   always_comb begin
      enc_raw = NopWord;
      op_ok   = 1'b1;
      case (in_op)
         OpReg: begin
            enc_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
         end
         OpLoad, OpJalr: begin
            enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
         end
         OpImm: begin
            if (shift_op) begin
               enc_raw = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
            end else begin
               enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
         end
         OpStore: begin
            enc_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
         end
         OpBranch: begin
            enc_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_op};
         end
         OpAuipc, OpLui: begin
            enc_raw = {in_imm[31:12], in_rd, in_op};
         end
         OpJal: begin
            enc_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
         end
         default: begin
            enc_raw = NopWord;
            op_ok   = 1'b0;
         end
      endcase
   end

`ifdef IMM_CHECK_EN
   // True when imm[31:msb] are all copies of one bit, i.e. imm fits a signed (msb+1)-bit field.
   function automatic logic sext_fits(input logic [31:0] imm, input int unsigned msb);
      logic [31:0] mask;
      mask = 32'hffff_ffff << msb;
      return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
   endfunction

   always_comb begin
      imm_ok = 1'b1;
      case (in_op)
         OpLoad, OpJalr, OpStore: imm_ok = sext_fits(in_imm, 11);
         OpImm:                   imm_ok = shift_op ? (in_imm[31:5] == '0) : sext_fits(in_imm, 11);
         OpBranch:                imm_ok = !in_imm[0] && sext_fits(in_imm, 12);
         OpJal:                   imm_ok = !in_imm[0] && sext_fits(in_imm, 20);
         OpAuipc, OpLui:          imm_ok = (in_imm[11:0] == 12'h000);
         default:                 imm_ok = 1'b1;
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   assign enc_err  = !(op_ok && imm_ok);
   assign enc_word = enc_err ? NopWord : enc_raw;

   // Flush outranks both accept and handshake; a same-cycle accept re-arms mem_we after a write.
   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      full_d  = full_q;
      err_d   = err_q;
      if (flush) begin
         we_d    = 1'b0;
         addr_d  = '0;
         wdata_d = '0;
         full_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         if (handshake) begin
            we_d   = 1'b0;
            addr_d = addr_q + AddrStep;
            if (addr_q == LastAddr) begin
               full_d = 1'b1;
            end
         end
         if (accept) begin
            we_d    = 1'b1;
            wdata_d = enc_word;
            if (enc_err) begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign full      = full_q;
   assign err       = err_q;

   a_word_aligned: assert property (@(posedge clk) disable iff (rst) mem_addr[1:0] == 2'b00);
   a_full_blocks: assert property (@(posedge clk) disable iff (rst) full |-> !in_ready);
   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (mem_we && !mem_ready && !flush) |=> (mem_we && $stable(mem_wdata) && $stable(mem_addr)));

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; a 12-bit-address instance for encoding,
// stall and flush behaviour plus a 4-bit-address instance for wrap/full behaviour.
module tb_instr_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, in_ready, mem_ready;
   logic [6:0]  in_op, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;
   logic        mem_we, full, err;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;

   logic        flush_s, in_valid_s, in_ready_s, mem_we_s, full_s, err_s;
   logic [3:0]  mem_addr_s;
   logic [31:0] mem_wdata_s;

   int          checks = 0;
   int          failures = 0;
   int          writes = 0;
   logic [31:0] exp_q[$];
   logic [11:0] mon_addr = '0;
   logic [4:0]  r_rd, r_rs1, r_rs2;
   logic [2:0]  r_f3;
   logic [6:0]  r_f7;
   logic [31:0] big_word;
   logic        big_err;

`ifdef IMM_CHECK_EN
   initial begin
      big_word = 32'h0000_0013;
      big_err  = 1'b1;
   end
`else
   initial begin
      big_word = 32'h0000_0093;
      big_err  = 1'b0;
   end
`endif

   instr_encoder #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .full(full), .err(err)
   );

   instr_encoder #(.ADDR_WIDTH(4)) dut_small (
      .clk(clk), .rst(rst), .flush(flush_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
      .mem_wdata(mem_wdata_s), .mem_ready(1'b1), .full(full_s), .err(err_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard side: each write handshake retires the oldest expected word.
   always @(negedge clk) begin
      if (!rst && !flush && mem_we && mem_ready) begin
         check_eq("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check_eq("sb_wdata", mem_wdata, exp_q.pop_front());
            check_eq("sb_addr", 32'(mem_addr), 32'(mon_addr));
         end
         mon_addr = mon_addr + 12'd4;
         writes++;
      end
   end

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] exp, input string tag);
      bit took;
      took      = 1'b0;
      in_op     = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
      in_valid  = 1'b1;
      for (int i = 0; i < 20 && !took; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            took = 1'b1;
         end
      end
      if (!took) check_eq({tag, "_accept_timeout"}, 32'(took), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      flush_s = 1'b0; in_valid_s = 1'b0;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
      in_imm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_we", 32'(mem_we), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // addi x1,x0,5: one-cycle latency
      send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, "addi");
      @(negedge clk);
      check_eq("addi_we", 32'(mem_we), 32'd1);
      check_eq("addi_addr", 32'(mem_addr), 32'h000);
      check_eq("addi_wdata", mem_wdata, 32'h0050_0093);
      @(posedge clk); #1;

      send(7'd99, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, "beq");
      send(7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h0100_00EF, "jal");
      send(7'd55, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, "lui");
      send(7'd19, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'd7, 32'h0072_1193, "slli");
      send(7'd19, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7, 32'h4072_5193, "srai");
      send(7'd23, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1097, "auipc");
      @(posedge clk); #1;

      // sw x2,8(x1) stalled three cycles
      mem_ready = 1'b0;
      send(7'd35, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, "sw");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("stall_we", 32'(mem_we), 32'd1);
         check_eq("stall_wdata", mem_wdata, 32'h0020_A423);
         check_eq("stall_addr", 32'(mem_addr), 32'h01C);
         check_eq("stall_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("release_addr", 32'(mem_addr), 32'h020);
      check_eq("release_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         r_rd = 5'($urandom); r_rs1 = 5'($urandom); r_rs2 = 5'($urandom);
         r_f3 = 3'($urandom); r_f7 = 7'($urandom);
         send(7'd51, r_rd, r_rs1, r_rs2, r_f3, r_f7, $urandom,
              {r_f7, r_rs2, r_rs1, r_f3, r_rd, 7'b0110011}, "rtype");
      end
      @(posedge clk); #1;

      // illegal opcode -> NOP, sticky err
      send(7'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h0000_0013, "illegal");
      @(negedge clk);
      check_eq("illegal_err", 32'(err), 32'd1);
      check_eq("illegal_wdata", mem_wdata, 32'h0000_0013);
      @(posedge clk); #1;
      send(7'd19, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, "addi_after_err");
      @(negedge clk);
      check_eq("err_sticky", 32'(err), 32'd1);
      @(posedge clk); #1;

      // flush discards a stalled word
      mem_ready = 1'b0;
      send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, "addi_flushed");
      flush = 1'b1;
      @(negedge clk);
      check_eq("flush_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      void'(exp_q.pop_back());
      mon_addr = '0;
      mem_ready = 1'b1;
      @(negedge clk);
      check_eq("flush_we", 32'(mem_we), 32'd0);
      check_eq("flush_addr", 32'(mem_addr), 32'd0);
      check_eq("flush_err", 32'(err), 32'd0);
      check_eq("flush_ready_after", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // addi x1,x0,4096
      send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, big_word, "addi4096");
      @(negedge clk);
      check_eq("imm4096_err", 32'(err), 32'(big_err));
      @(posedge clk); #1;

      // ADDR_WIDTH=4 instance: four back-to-back words fill it
      in_valid_s = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("small_we", 32'(mem_we_s), 32'd1);
         check_eq("small_addr", 32'(mem_addr_s), 32'(i * 4));
         check_eq("small_wdata", mem_wdata_s, big_word);
         if (i == 3) in_valid_s = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      check_eq("small_full", 32'(full_s), 32'd1);
      check_eq("small_wrap_addr", 32'(mem_addr_s), 32'd0);
      check_eq("small_full_ready", 32'(in_ready_s), 32'd0);
      check_eq("small_we_idle", 32'(mem_we_s), 32'd0);
      check_eq("small_err", 32'(err_s), 32'(big_err));
      flush_s = 1'b1;
      @(posedge clk); #1;
      flush_s = 1'b0;
      @(negedge clk);
      check_eq("small_flush_full", 32'(full_s), 32'd0);
      check_eq("small_flush_ready", 32'(in_ready_s), 32'd1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      check_eq("write_count", 32'(writes), 32'd16);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
